// File: rtl/rs_age_issue_if.sv
// Bundles the insert, wakeup-broadcast, issue and status signals of the
// age-ordered reservation station. The master drives requests and the slave is the station.
interface rs_age_issue_if #(
    parameter int RS_SIZE_BIT   = 3,
    parameter int ROB_WIDTH_BIT = 4,
    parameter int TYPE_BIT      = 4,
    parameter int NUM_CDB       = 2
);
    logic                          inst_valid;
    logic [TYPE_BIT-1:0]           inst_type;
    logic [ROB_WIDTH_BIT-1:0]      inst_rob_id;
    logic [31:0]                   inst_r1;
    logic [31:0]                   inst_r2;
    logic [ROB_WIDTH_BIT-1:0]      inst_dep1;
    logic [ROB_WIDTH_BIT-1:0]      inst_dep2;
    logic                          inst_has_dep1;
    logic                          inst_has_dep2;
    logic                          full;
    logic [RS_SIZE_BIT:0]          count;
    logic [NUM_CDB-1:0]            cdb_valid;
    logic [NUM_CDB*ROB_WIDTH_BIT-1:0] cdb_rob_id;
    logic [NUM_CDB*32-1:0]         cdb_value;
    logic                          issue_valid;
    logic                          issue_ready;
    logic [TYPE_BIT-1:0]           issue_type;
    logic [ROB_WIDTH_BIT-1:0]      issue_rob_id;
    logic [31:0]                   issue_r1;
    logic [31:0]                   issue_r2;
    logic [31:0]                   stat_issued;
    logic [31:0]                   stat_full_cycles;

    modport master (
        output inst_valid, inst_type, inst_rob_id, inst_r1, inst_r2,
               inst_dep1, inst_dep2, inst_has_dep1, inst_has_dep2,
               cdb_valid, cdb_rob_id, cdb_value, issue_ready,
        input  full, count, issue_valid, issue_type, issue_rob_id,
               issue_r1, issue_r2, stat_issued, stat_full_cycles
    );

    modport slave (
        input  inst_valid, inst_type, inst_rob_id, inst_r1, inst_r2,
               inst_dep1, inst_dep2, inst_has_dep1, inst_has_dep2,
               cdb_valid, cdb_rob_id, cdb_value, issue_ready,
        output full, count, issue_valid, issue_type, issue_rob_id,
               issue_r1, issue_r2, stat_issued, stat_full_cycles
    );
endinterface

// File: rtl/rs_age_issue.sv
// Reservation station with CDB wakeup and oldest-ready issue selection using an age matrix.
// Optional statistics counters are enabled by defining RS_STAT_EN.
module rs_age_issue #(
    parameter int RS_SIZE_BIT   = 3,
    parameter int ROB_WIDTH_BIT = 4,
    parameter int TYPE_BIT      = 4,
    parameter int NUM_CDB       = 2
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           flush,
    rs_age_issue_if.slave  bus
);
    localparam int N = 1 << RS_SIZE_BIT;

    logic [N-1:0]             busy;
    logic [N-1:0]             pend1;
    logic [N-1:0]             pend2;
    logic [TYPE_BIT-1:0]      typ  [N];
    logic [ROB_WIDTH_BIT-1:0] rob  [N];
    logic [ROB_WIDTH_BIT-1:0] dep1 [N];
    logic [ROB_WIDTH_BIT-1:0] dep2 [N];
    logic [31:0]              val1 [N];
    logic [31:0]              val2 [N];
    // older[i][j] set means entry i was inserted before entry j
    logic [N-1:0]             older [N];

    logic [N-1:0]             issuable;
    logic [N-1:0]             sel;
    logic                     issue_fire;
    logic                     ins_fire;
    logic [RS_SIZE_BIT-1:0]   ins_idx;
    logic                     full_int;
    logic [RS_SIZE_BIT:0]     cnt;

    logic [N-1:0]             hit1;
    logic [N-1:0]             hit2;
    logic [31:0]              wval1 [N];
    logic [31:0]              wval2 [N];
    logic                     ins_hit1;
    logic                     ins_hit2;
    logic [31:0]              ins_val1;
    logic [31:0]              ins_val2;

    assign issuable = busy & ~pend1 & ~pend2;
    assign full_int = &busy;

    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            sel[i] = issuable[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && issuable[j] && older[j][i])
                    sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        bus.issue_type   = '0;
        bus.issue_rob_id = '0;
        bus.issue_r1     = '0;
        bus.issue_r2     = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                bus.issue_type   = bus.issue_type   | typ[i];
                bus.issue_rob_id = bus.issue_rob_id | rob[i];
                bus.issue_r1     = bus.issue_r1     | val1[i];
                bus.issue_r2     = bus.issue_r2     | val2[i];
            end
        end
    end

    assign bus.issue_valid = (|issuable) & rdy_in & ~flush;
    assign issue_fire      = bus.issue_valid & bus.issue_ready;

    // Only registered busy bits are used, so a slot freed this cycle is not reused until next
    always_comb begin
        ins_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i])
                ins_idx = RS_SIZE_BIT'(i);
        end
    end

    assign ins_fire = bus.inst_valid & ~full_int & rdy_in & ~flush;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++)
            cnt = cnt + (RS_SIZE_BIT+1)'(busy[i]);
    end

    assign bus.full  = full_int;
    assign bus.count = cnt;

    // Channels scanned high to low so the lowest matching channel wins
    always_comb begin
        hit1     = '0;
        hit2     = '0;
        ins_hit1 = 1'b0;
        ins_hit2 = 1'b0;
        ins_val1 = '0;
        ins_val2 = '0;
        for (int i = 0; i < N; i++) begin
            wval1[i] = '0;
            wval2[i] = '0;
        end
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (bus.cdb_valid[k]) begin
                for (int i = 0; i < N; i++) begin
                    if (busy[i] && pend1[i] &&
                        dep1[i] == bus.cdb_rob_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT]) begin
                        hit1[i]  = 1'b1;
                        wval1[i] = bus.cdb_value[k*32 +: 32];
                    end
                    if (busy[i] && pend2[i] &&
                        dep2[i] == bus.cdb_rob_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT]) begin
                        hit2[i]  = 1'b1;
                        wval2[i] = bus.cdb_value[k*32 +: 32];
                    end
                end
                if (bus.inst_has_dep1 &&
                    bus.inst_dep1 == bus.cdb_rob_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT]) begin
                    ins_hit1 = 1'b1;
                    ins_val1 = bus.cdb_value[k*32 +: 32];
                end
                if (bus.inst_has_dep2 &&
                    bus.inst_dep2 == bus.cdb_rob_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT]) begin
                    ins_hit2 = 1'b1;
                    ins_val2 = bus.cdb_value[k*32 +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy  <= '0;
            pend1 <= '0;
            pend2 <= '0;
            for (int i = 0; i < N; i++)
                older[i] <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                busy <= '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (hit1[i]) begin
                        val1[i]  <= wval1[i];
                        pend1[i] <= 1'b0;
                    end
                    if (hit2[i]) begin
                        val2[i]  <= wval2[i];
                        pend2[i] <= 1'b0;
                    end
                    if (issue_fire && sel[i])
                        busy[i] <= 1'b0;
                end
                if (ins_fire) begin
                    busy[ins_idx]  <= 1'b1;
                    typ[ins_idx]   <= bus.inst_type;
                    rob[ins_idx]   <= bus.inst_rob_id;
                    dep1[ins_idx]  <= bus.inst_dep1;
                    dep2[ins_idx]  <= bus.inst_dep2;
                    pend1[ins_idx] <= bus.inst_has_dep1 & ~ins_hit1;
                    pend2[ins_idx] <= bus.inst_has_dep2 & ~ins_hit2;
                    val1[ins_idx]  <= ins_hit1 ? ins_val1 : bus.inst_r1;
                    val2[ins_idx]  <= ins_hit2 ? ins_val2 : bus.inst_r2;
                    older[ins_idx] <= '0;
                    for (int j = 0; j < N; j++)
                        older[j][ins_idx] <= busy[j];
                end
            end
        end
    end

`ifdef RS_STAT_EN
    logic [31:0] issued_q;
    logic [31:0] full_cycles_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            issued_q      <= '0;
            full_cycles_q <= '0;
        end else if (rdy_in) begin
            if (issue_fire)
                issued_q <= issued_q + 32'd1;
            if (full_int)
                full_cycles_q <= full_cycles_q + 32'd1;
        end
    end

    assign bus.stat_issued      = issued_q;
    assign bus.stat_full_cycles = full_cycles_q;
`else
    assign bus.stat_issued      = '0;
    assign bus.stat_full_cycles = '0;
`endif

endmodule

// File: doc/rs_age_issue.md
RS_AGE_ISSUE -- requirements
Module: rs_age_issue

Interface
REQ-001 SHALL have parameter RS_SIZE_BIT, default 3: log2 of entry count; depth N = 2^RS_SIZE_BIT.
REQ-002 SHALL have parameter ROB_WIDTH_BIT, default 4: ROB tag width.
REQ-003 SHALL have parameter TYPE_BIT, default 4: operation type width.
REQ-004 SHALL have parameter NUM_CDB, default 2: number of result broadcast channels.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_in, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port rdy_in, input, 1 bit: global enable; low pauses the block.
REQ-008 SHALL have port flush, input, 1 bit: misprediction clear.
REQ-009 SHALL have port inst_valid, input, 1 bit: insert request.
REQ-010 SHALL have port inst_type, input, TYPE_BIT bits: operation type.
REQ-011 SHALL have port inst_rob_id, input, ROB_WIDTH_BIT bits: destination tag.
REQ-012 SHALL have ports inst_r1 and inst_r2, input, 32 bits each: operand values.
REQ-013 SHALL have ports inst_dep1 and inst_dep2, input, ROB_WIDTH_BIT bits each: operand producer tags.
REQ-014 SHALL have ports inst_has_dep1 and inst_has_dep2, input, 1 bit each: operand pending flags.
REQ-015 SHALL have port full, output, 1 bit: no free entry.
REQ-016 SHALL have port count, output, RS_SIZE_BIT+1 bits: occupied entries.
REQ-017 SHALL have port cdb_valid, input, NUM_CDB bits: broadcast valid per channel.
REQ-018 SHALL have port cdb_rob_id, input, NUM_CDB*ROB_WIDTH_BIT bits: packed tags, channel k at slice k.
REQ-019 SHALL have port cdb_value, input, NUM_CDB*32 bits: packed values.
REQ-020 SHALL have port issue_valid, output, 1 bit: issue candidate present.
REQ-021 SHALL have port issue_ready, input, 1 bit: execution unit accepts.
REQ-022 SHALL have ports issue_type (TYPE_BIT), issue_rob_id (ROB_WIDTH_BIT), issue_r1 (32), issue_r2 (32), all outputs: selected entry payload.
REQ-023 SHALL have ports stat_issued and stat_full_cycles, output, 32 bits each: statistics.

Function
REQ-024 An entry SHALL be issuable when busy and both pending flags are clear, using registered state only.
REQ-025 issue_valid SHALL be high when any entry is issuable, rdy_in=1 and flush=0; the payload SHALL come combinationally from the oldest issuable entry.
REQ-026 Age SHALL be tracked by an N x N age matrix; an inserted entry SHALL be younger than all busy entries.
REQ-027 The selected entry SHALL be freed at the clock edge where issue_valid && issue_ready.
REQ-028 The payload SHALL be held stable while issue_valid=1 and issue_ready=0, unless an older entry becomes issuable.
REQ-029 Insert SHALL write the lowest-index free entry when inst_valid=1, full=0 and rdy_in=1; a slot freed in the same cycle SHALL NOT be reused that cycle.
REQ-030 An insert while full=1 SHALL be ignored, with no state change.
REQ-031 On insert, an operand with has_dep set whose tag matches any valid CDB channel that cycle SHALL capture that channel's value and clear its pending flag.
REQ-032 Each cycle, every busy entry with a pending operand matching a valid CDB channel SHALL capture the value and clear the flag; the entry SHALL be issuable from the next cycle (1-cycle wakeup latency).
REQ-033 If several channels match the same operand, the lowest channel index SHALL win.
REQ-034 full SHALL equal all entries busy; count SHALL equal the number of busy entries; both SHALL be registered-state derived.
REQ-035 flush=1 (with rdy_in=1) SHALL clear all busy bits at the edge, overriding insert and issue; issue_valid SHALL be 0 during flush.
REQ-036 rdy_in=0 SHALL hold all state; issue_valid SHALL be 0 and CDB and insert inputs SHALL be ignored.

Reset
REQ-037 With rst_in=1 at a clock edge, all busy and pending flags, the age matrix and the stat counters SHALL clear; reset SHALL take priority over rdy_in and flush.
REQ-038 After reset, full=0, count=0, issue_valid=0, the issue payload SHALL be 0 and stat outputs SHALL be 0.

Configuration
REQ-039 With macro RS_STAT_EN defined, stat_issued SHALL increment on each accepted issue and stat_full_cycles SHALL increment each rdy_in=1 cycle with full=1; both SHALL wrap modulo 2^32 and clear on reset only.
REQ-040 Without RS_STAT_EN, both stat outputs SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-041 Insert A (tag 1, no deps), then B (tag 2, no deps), with issue_ready=1 -> A issues in the next cycle, then B; count goes 1,1,0.
REQ-042 Insert C (tag 3, dep1=5 pending), then a CDB0 broadcast of tag 5 value 0x1234 -> C issues exactly 1 cycle later with issue_r1=0x1234.
REQ-043 Insert an entry with dep2=6 in the same cycle CDB1 broadcasts tag 6 value 0xBEEF -> the entry issues next cycle with issue_r2=0xBEEF.
REQ-044 Fill N=8 entries with issue_ready=0, then insert once more -> full=1, count=8, the extra insert is dropped; with RS_STAT_EN, stat_full_cycles counts these cycles.
REQ-045 With 5 busy entries, assert flush together with inst_valid -> count=0 and issue_valid=0 next cycle.
REQ-046 Make a younger entry ready before an older one, then make the older one ready -> the older one issues first.
